// File: rtl/onehot_pkg.sv
// ============================================================================
// onehot_pkg : shared sizing helpers for the one-hot stream encoder. Rev 1.0
// ============================================================================
`default_nettype none

package onehot_pkg;

  localparam int ONEHOT_N = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Payload is packed as {err, idx}; err sits directly above the index field.
  function automatic int payload_err_pos(input int idx_w);
    return idx_w;
  endfunction

  localparam int ONEHOT_W = clog2(ONEHOT_N);
  localparam int ERR_BIT  = payload_err_pos(ONEHOT_W);

endpackage

`default_nettype wire

// File: rtl/onehot_enc_core.sv
// ============================================================================
// onehot_enc_core : combinational priority one-hot to binary encoder. Rev 1.0
// ============================================================================
`default_nettype none

module onehot_enc_core
  import onehot_pkg::*;
#(
  parameter int N         = ONEHOT_N,
  parameter int W         = clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         is_zero,
  output logic         is_multi
);

  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (onehot[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (onehot[i]) idx = W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only for multi-hot.
  assign is_zero  = (onehot == '0);
  assign is_multi = |(onehot & (onehot - N'(1)));

endmodule

`default_nettype wire

// File: rtl/onehot_enc_stream.sv
// ============================================================================
// onehot_enc_stream : valid/ready one-hot encoder with skid buffer. Rev 1.0
// ============================================================================
`default_nettype none

module onehot_enc_stream
  import onehot_pkg::*;
#(
  parameter int N         = ONEHOT_N,
  parameter int W         = clog2(N),
  parameter bit MSB_FIRST = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         bin,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam int                   EP      = payload_err_pos(W);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] enc_idx;
  logic         enc_zero;
  logic         enc_multi;
  logic         enc_err;
  logic [W:0]   in_pay;

  onehot_enc_core #(
    .N         (N),
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .onehot   (onehot),
    .idx      (enc_idx),
    .is_zero  (enc_zero),
    .is_multi (enc_multi)
  );

  assign enc_err = enc_zero | enc_multi;
  assign in_pay  = {enc_err, enc_idx};

  logic                 skid_valid_q, skid_valid_d;
  logic [W:0]           skid_pay_q,   skid_pay_d;
  logic                 out_valid_q,  out_valid_d;
  logic [W:0]           out_pay_q,    out_pay_d;
  logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;

  logic in_xfer;
  logic out_free;

  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid & in_ready;
  assign out_free = !out_valid_q | out_ready;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;
    out_valid_d  = out_valid_q;
    out_pay_d    = out_pay_q;
    if (out_free) begin
      // Skid entry is older than anything arriving now, so it goes first.
      if (skid_valid_q) begin
        out_pay_d    = skid_pay_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_xfer;
        if (in_xfer) skid_pay_d = in_pay;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) out_pay_d = in_pay;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = in_pay;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = (in_xfer && enc_err) ? ERR_CNT_W'(1) : '0;
    end else if (in_xfer && enc_err && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_pay_q   <= '0;
      out_valid_q  <= 1'b0;
      out_pay_q    <= '0;
      err_count_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
      out_valid_q  <= out_valid_d;
      out_pay_q    <= out_pay_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bin       = out_pay_q[W-1:0];
  assign err       = out_pay_q[EP];
  assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: doc/onehot_enc_stream.md
Name: onehot_enc_stream

Overview:
- Streaming, parametrised successor of the pooling-filter one-hot→binary encoder.
- Accepts an N-bit one-hot word per valid/ready beat and emits its W-bit index with one-cycle registered latency at full throughput.
- Flags zero-hot and multi-hot words and keeps a saturating error count.
- Sits between the pooling comparator stage (one-hot winner select) and downstream index/address logic, and replaces the purely combinational encoder where backpressure is needed.

Parameters:
- N, 16: one-hot input width (≥2).
- W, $clog2(N): binary index width (derived; do not override).
- MSB_FIRST, 1: on multi-hot, 1 = highest set index wins, 0 = lowest set index wins.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- onehot  in  N  one-hot input word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- bin  out  W  encoded index.
- err  out  1  the word on bin was not exactly one-hot.
- err_count  out  ERR_CNT_W  saturating count of accepted erroneous words.
- err_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - out_valid=0, bin=0, err=0, err_count=0, skid empty.
  - in_ready=1 from the first cycle after reset deasserts.
  - Inputs are ignored while rst_n=0.
  - Reset mid-stream drops all held beats; nothing is replayed.
- Encoding (combinational core):
  - idx = highest set bit (MSB_FIRST=1) or lowest set bit (MSB_FIRST=0).
  - Zero-hot: idx=0.
  - err = (popcount(onehot) != 1).
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Storage:
  - Output register {bin, err, out_valid}.
  - One-entry skid register {idx, err, skid_valid}.
- in_ready = !skid_valid. This is a registered source with no combinational path from out_ready.
- Per cycle:
  - Output register empty, or being drained this cycle: a source moves into it. The source is the skid entry if valid, else the accepted input. If the skid drains and an input is accepted in the same cycle, the input goes to the skid.
  - Output register full and stalled (out_valid & !out_ready): an accepted input goes to the skid.
  - Neither case: registers hold.
  - bin and err are stable while out_valid=1 and out_ready=0.
- Ordering: strictly FIFO. No beat is lost or duplicated under any out_ready pattern.
- Latency: 1 cycle from input transfer to out_valid when unstalled. Sustained throughput is 1 beat/cycle with out_ready=1.
- err_count:
  - Increments by 1 on each input transfer whose word has err=1.
  - Saturates at 2^ERR_CNT_W−1; it does not wrap.
  - err_clr=1 zeroes the count. If an erroneous transfer occurs in the same cycle as err_clr, the result is 1.
- The encoded value has no dependence on the previous word. in_valid dropping mid-stream inserts bubbles only.

Decomposition:
- Shared package/header onehot_pkg holds:
  - Default ONEHOT_N = 16.
  - A clog2 helper function.
  - A localparam for the err flag bit position in the packed {err, idx} payload, which is reused by skid and output registers.
- Sub-module onehot_enc_core, combinational, params N and MSB_FIRST. Outputs idx[W-1:0], is_zero, is_multi.
  - Instantiated once on the input side.
  - Unit-tested standalone, exhaustively over all single-hot values for N=16.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=1, onehot=16'h0001 → out_valid=0, err_count=0 throughout; in_ready=1 in the cycle after rst_n=1.
- Single beat: onehot=16'h0020 accepted, out_ready=1 → next cycle out_valid=1, bin=5, err=0.
- Back-to-back: 16'h0001, 16'h8000, 16'h0100 on consecutive cycles, out_ready=1 → bin=0, 15, 8 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0; feed 16'h0004 then 16'h0008.
  - bin=2 is held, and in_ready=0 after the second accept.
  - A third word offered meanwhile is not accepted.
  - Release out_ready=1 → bin=2, then 3, then the third word; no loss or reorder.
- Errors (MSB_FIRST=1): 16'h0000 → bin=0, err=1; 16'h0240 → bin=9, err=1; err_count=2. Rerun with MSB_FIRST=0: 16'h0240 → bin=6, err=1.
- Saturation/clear, ERR_CNT_W=2: 5 erroneous words → err_count=3. Then err_clr=1 in the same cycle as an erroneous transfer → err_count=1 next cycle.
